// File: rtl/ifetch32_seq.sv
// Instruction-fetch stage: owns the PC, fetches through a req/ack handshake with a
// bounded wait, and presents the latched instruction to decode for one or more cycles.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | request low for one cycle (after reset or after a fetch timeout)
// REQ   | imem_req high at PC, waiting for imem_ack or the timeout
// EXEC  | Instruction valid for decode; leaves on the first cycle without stall
module ifetch32_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14,
    parameter int          TIMEOUT  = 64
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    input  logic               stall,
    input  logic [31:0]        Addr_result,
    input  logic [31:0]        Read_data_1,
    input  logic               Zero,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    output logic [31:0]        Instruction,
    output logic [31:0]        PC,
    output logic [31:0]        PC_plus_4,
    output logic [31:0]        opcplus4,
    output logic               insn_valid,
    output logic               fetch_err
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   pc_q;
    logic [31:0]   insn_q;
    logic [31:0]   opc_q;
    logic          err_q;

    logic          fetch_done;
    logic          fetch_timeout;
    logic          leave_exec;
    logic [31:0]   pc_plus_4;
    logic          take_branch;
    logic [31:0]   next_pc;

    assign pc_plus_4   = pc_q + 32'd4;
    assign take_branch = (Branch & Zero) | (nBranch & ~Zero);

    // Jr outranks everything so a jal/jr collision still returns through rs.
    always_comb begin
        next_pc = pc_plus_4;
        if (Jr) begin
            next_pc = Read_data_1 & 32'hFFFF_FFFC;
        end else if (Jmp || Jal) begin
            next_pc = {pc_plus_4[31:28], insn_q[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = Addr_result & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // An ack on the terminal-count cycle is taken ahead of the timeout.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_done    = 1'b0;
        fetch_timeout = 1'b0;
        leave_exec    = 1'b0;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                state_d    = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = EXEC;
                end else if (wait_cnt_q == CNT_LAST) begin
                    fetch_timeout = 1'b1;
                    wait_cnt_d    = '0;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            EXEC: begin
                wait_cnt_d = '0;
                if (!stall) begin
                    leave_exec = 1'b1;
                    state_d    = REQ;
                end
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_PC;
            insn_q <= '0;
            opc_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (fetch_done) begin
                insn_q <= imem_rdata;
            end
            if (fetch_timeout) begin
                err_q <= 1'b1;
            end
            if (leave_exec) begin
                pc_q <= next_pc;
                if (Jal) begin
                    opc_q <= pc_plus_4;
                end
            end
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign insn_valid  = (state_q == EXEC);
    assign Instruction = insn_q;
    assign PC          = pc_q;
    assign PC_plus_4   = pc_plus_4;
    assign opcplus4    = opc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch32_seq.sv
// Bench for ifetch32_seq: a latency-programmable instruction memory plus a PC/return-address
// model that follows the fetch rules, driven by directed cases and a randomized run.
module tb_ifetch32_seq;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic [31:0] Addr_result;
    logic [31:0] Read_data_1;
    logic        Zero;
    logic        Branch;
    logic        nBranch;
    logic        Jmp;
    logic        Jal;
    logic        Jr;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] PC_plus_4;
    logic [31:0] opcplus4;
    logic        insn_valid;
    logic        fetch_err;

    ifetch32_seq #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (14),
        .TIMEOUT  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .Zero        (Zero),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Instruction (Instruction),
        .PC          (PC),
        .PC_plus_4   (PC_plus_4),
        .opcplus4    (opcplus4),
        .insn_valid  (insn_valid),
        .fetch_err   (fetch_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:16383];
    int          mem_lat = 1;   // 0 = memory never acks
    int          req_age = 0;
    logic [31:0] m_pc;
    logic [31:0] m_opc;
    logic        m_err;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_BEQ  = 5'b00001;
    localparam logic [4:0] C_BNE  = 5'b00010;
    localparam logic [4:0] C_JAL  = 5'b01000;
    localparam logic [4:0] C_JR   = 5'b10000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_respond();
        if (imem_req) begin
            req_age++;
            if (mem_lat != 0 && req_age == mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
        end else begin
            req_age  = 0;
            imem_ack = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        mem_respond();
    endtask

    task automatic drive_ctl(input logic [4:0] ctl, input logic z, input logic [31:0] ar,
                             input logic [31:0] rd1);
        Branch      = ctl[0];
        nBranch     = ctl[1];
        Jmp         = ctl[2];
        Jal         = ctl[3];
        Jr          = ctl[4];
        Zero        = z;
        Addr_result = ar;
        Read_data_1 = rd1;
    endtask

    // Fetch at m_pc, hold EXEC for 'stalls' cycles, then leave with the given controls.
    task automatic run_insn(input logic [4:0] ctl, input logic z, input logic [31:0] ar,
                            input logic [31:0] rd1, input int stalls, input int nxt_lat);
        int          n;
        int          reqc;
        logic [31:0] insn;
        logic [31:0] p4;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        n    = 0;
        reqc = 0;
        while (!insn_valid && n < 40) begin
            if (imem_req) begin
                reqc++;
                check("imem_addr", {18'b0, imem_addr}, {18'b0, m_pc[15:2]});
            end
            tick();
            n++;
        end
        check("fetch_wait", {31'b0, insn_valid}, 32'd1);
        check("req_cycles", reqc, mem_lat);
        insn = mem[m_pc[15:2]];
        p4   = m_pc + 32'd4;
        check("exec_pc", PC, m_pc);
        check("exec_insn", Instruction, insn);
        check("pc_plus_4", PC_plus_4, p4);
        check("exec_req", {31'b0, imem_req}, 32'd0);
        check("exec_err", {31'b0, fetch_err}, {31'b0, m_err});
        check("exec_opc", opcplus4, m_opc);
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            drive_ctl(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            tick();
            check("stall_valid", {31'b0, insn_valid}, 32'd1);
            check("stall_pc", PC, m_pc);
            check("stall_insn", Instruction, insn);
            check("stall_opc", opcplus4, m_opc);
            check("stall_req", {31'b0, imem_req}, 32'd0);
        end
        drive_ctl(ctl, z, ar, rd1);
        stall   = 1'b0;
        mem_lat = nxt_lat;
        tgt     = (p4 & 32'hF000_0000) | ((insn & 32'h03FF_FFFF) * 4);
        if (ctl[4])
            exp_pc = rd1 - (rd1 % 4);
        else if (ctl[2] || ctl[3])
            exp_pc = tgt;
        else if ((ctl[0] && z) || (ctl[1] && !z))
            exp_pc = ar - (ar % 4);
        else
            exp_pc = p4;
        if (ctl[3])
            m_opc = p4;
        m_pc = exp_pc;
        tick();
        check("next_pc", PC, m_pc);
        check("next_opc", opcplus4, m_opc);
        check("left_exec", {31'b0, insn_valid}, 32'd0);
        drive_ctl(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    initial begin
        int n;
        int reqc;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[8] = {6'b000011, 26'h000_0100};
        reset = 1'b0;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        drive_ctl(C_NONE, 1'b0, '0, '0);
        m_pc  = 32'h0;
        m_opc = 32'h0;
        m_err = 1'b0;

        #1 reset = 1'b1;
        #2;
        check("rst_pc", PC, 32'h0);
        check("rst_insn", Instruction, 32'h0);
        check("rst_opc", opcplus4, 32'h0);
        check("rst_valid", {31'b0, insn_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        mem_respond();
        check("idle_req", {31'b0, imem_req}, 32'd0);
        tick();

        // sequential fetches, then branch/jump directed cases
        run_insn(C_NONE, 1'b0, 32'h0, 32'h0, 0, 1);
        run_insn(C_NONE, 1'b0, 32'h0, 32'h0, 0, 1);
        run_insn(C_JR,   1'b0, 32'h0, 32'h13, 0, 1);
        run_insn(C_BEQ,  1'b1, 32'h40, 32'h0, 0, 2);
        run_insn(C_JR,   1'b0, 32'h0, 32'h10, 0, 1);
        run_insn(C_BEQ,  1'b0, 32'h40, 32'h0, 0, 1);
        run_insn(C_JR,   1'b0, 32'h0, 32'h10, 0, 3);
        run_insn(C_BNE,  1'b0, 32'h41, 32'h0, 0, 1);
        run_insn(C_JR,   1'b0, 32'h0, 32'h20, 0, 1);
        run_insn(C_JAL,  1'b0, 32'h0, 32'h0, 3, 1);
        run_insn(C_JR,   1'b0, 32'h0, 32'h27, 0, 4);
        run_insn(C_JAL | C_JR, 1'b0, 32'h0, 32'h1000, 1, 0);

        // memory silent: timeout, one idle cycle, refetch of the same word
        n    = 0;
        reqc = 0;
        while (imem_req && n < 20) begin
            check("to_addr", {18'b0, imem_addr}, {18'b0, m_pc[15:2]});
            reqc++;
            tick();
            n++;
        end
        check("to_req_cycles", reqc, 4);
        check("to_err", {31'b0, fetch_err}, 32'd1);
        check("to_req_drop", {31'b0, imem_req}, 32'd0);
        m_err   = 1'b1;
        mem_lat = 2;
        tick();
        check("to_rereq", {31'b0, imem_req}, 32'd1);
        check("to_readdr", {18'b0, imem_addr}, {18'b0, m_pc[15:2]});

        run_insn(C_JR,   1'b0, 32'h0, 32'hFFFF_FFFE, 0, 1);
        run_insn(C_NONE, 1'b0, 32'h0, 32'h0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            run_insn(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     $urandom_range(0, 2), (k == 29) ? 0 : $urandom_range(1, 4));
        end

        // asynchronous reset between edges while waiting on memory
        #2 reset = 1'b1;
        #1;
        check("ar_req", {31'b0, imem_req}, 32'd0);
        check("ar_pc", PC, 32'h0);
        check("ar_err", {31'b0, fetch_err}, 32'd0);
        check("ar_opc", opcplus4, 32'h0);
        check("ar_insn", Instruction, 32'h0);
        @(negedge clock);
        reset      = 1'b0;
        req_age    = 0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        check("ar_idle_req", {31'b0, imem_req}, 32'd0);
        @(negedge clock);
        check("stale_ack_insn", Instruction, 32'h0);
        check("stale_ack_valid", {31'b0, insn_valid}, 32'd0);
        check("stale_ack_req", {31'b0, imem_req}, 32'd1);
        m_pc    = 32'h0;
        m_opc   = 32'h0;
        m_err   = 1'b0;
        mem_lat = 1;
        mem_respond();
        run_insn(C_NONE, 1'b0, 32'h0, 32'h0, 1, 2);
        run_insn(C_JAL,  1'b0, 32'h0, 32'h0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch32_seq.md
Name: ifetch32_seq

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file stage of the single-cycle MIPS32 core.
- Holds the PC and drives a variable-latency instruction memory through a req/ack handshake.
- Presents Instruction, PC_plus_4 and opcplus4 to decode/control; computes the next PC from branch/jump controls.
- Decode and control are combinational from Instruction; RegWrite is committed only on the insn_valid cycle.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 14, instruction-memory word-address width.
- TIMEOUT, 64, cycles to wait for imem_ack before aborting and retrying; minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  IMEM_AW  word address, PC[IMEM_AW+1:2].
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- imem_ack  in  1  one-cycle completion strobe.
- stall  in  1  hold the current instruction in EXEC.
- Addr_result  in  32  branch target from execute.
- Read_data_1  in  32  rs value, used by jr.
- Zero  in  1  ALU zero flag.
- Branch  in  1  beq.
- nBranch  in  1  bne.
- Jmp  in  1  j.
- Jal  in  1  jal.
- Jr  in  1  jr.
- Instruction  out  32  latched instruction word.
- PC  out  32  current PC.
- PC_plus_4  out  32  PC+4, combinational from PC.
- opcplus4  out  32  return address for jal, registered.
- insn_valid  out  1  Instruction is executing this cycle; decode may write back.
- fetch_err  out  1  sticky flag, a fetch timed out.

Behaviour:
- Reset (async, any state, including mid-wait):
  - PC=RESET_PC, Instruction=0 (nop), opcplus4=0, insn_valid=0, fetch_err=0, imem_req=0, timeout counter=0, state=IDLE.
- FSM states: IDLE, REQ, EXEC.
- IDLE: one cycle after reset deasserts, go to REQ.
- REQ:
  - imem_req=1; imem_addr=PC[IMEM_AW+1:2], stable while in REQ.
  - The counter increments each cycle.
  - On imem_ack: Instruction<=imem_rdata, counter<=0, go to EXEC.
  - If the counter reaches TIMEOUT-1 without ack: fetch_err<=1, imem_req drops for one cycle (IDLE), counter<=0, then refetch the same PC.
  - An ack arriving on the same edge as the timeout wins; fetch_err stays unchanged.
- EXEC:
  - insn_valid=1 and imem_req=0.
  - stall=1: remain in EXEC, PC and Instruction held, insn_valid stays 1.
  - stall=0: on the edge PC<=next_pc, go to REQ; insn_valid falls with the state change.
  - Fetch-to-first-execute latency is 1 cycle plus the memory latency.
- next_pc, first match wins:
  1. Jr: {Read_data_1[31:2],2'b00}.
  2. Jmp or Jal: {PC_plus_4[31:28],Instruction[25:0],2'b00}.
  3. (Branch & Zero) | (nBranch & ~Zero): {Addr_result[31:2],2'b00}.
  4. Otherwise: PC_plus_4.
- Targets always have bits [1:0] forced to 0.
- PC_plus_4 wraps modulo 2^32: PC=32'hFFFF_FFFC gives 32'h0000_0000.
- opcplus4 loads PC_plus_4 on the edge leaving EXEC with Jal=1; otherwise it holds.
- Simultaneous Jal and Jr: Jr target is taken, and opcplus4 is still loaded.
- imem_ack outside REQ is ignored.
- fetch_err clears only on reset.

Test Plan:
- Reset, RESET_PC=0, imem with 1-cycle ack: imem_addr 0,1,2 on successive REQ cycles; insn_valid pulses every 2 cycles; PC 0,4,8.
- beq at PC=0x10, Zero=1, Addr_result=0x40: next imem_addr=0x10. Same with Zero=0: next PC=0x14. bne with Zero=0: next PC=0x40.
- jal at PC=0x20 with Instruction[25:0]=0x000_0100:
  - next PC=0x400, opcplus4=0x24.
  - A following jr with Read_data_1=0x27 gives PC=0x24.
- stall held 3 cycles in EXEC: insn_valid high 3+1 cycles; PC and Instruction unchanged; no imem_req.
- Memory never acks, TIMEOUT=4: fetch_err=1 after 4 REQ cycles; req drops 1 cycle; same address re-requested; a later ack completes normally.
- Assert reset asynchronously mid-REQ (between edges): imem_req falls immediately; PC=RESET_PC; fetch_err=0; a stale ack after release is ignored.
